status_unit: RTL and testbench
==============================

STATUS_UNIT -- requirements
Module: status_unit

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- freeze  input  1  pipeline hold from the hazard unit; blocks ID issue.
- id_valid  input  1  ID holds a real instruction.
- id_s  input  1  ID instruction writes flags (S bit).
- id_cond  input  4  ID instruction condition field; 4'b1110 = AL.
- flag_we  input  1  the ALU commits flags this cycle.
- flag_in  input  4  committed flags {Z,C,N,V}.
- kill_s  input  1  an in-flight flag-setting instruction is squashed this cycle.
- status  output  4  {Z,C,N,V} presented to the condition checker.
- cond_stall  output  1  the ID instruction must hold because its flags are not yet available.
- issue  output  1  the ID instruction advances this cycle.
- pend_cnt  output  2  number of issued, uncommitted flag writers.
- err  output  1  sticky protocol error.

Function
REQ-002 The status register (SR) SHALL be 4 bits, ordered {Z,C,N,V}, and SHALL load flag_in on any rising edge where flag_we=1 and rst=0.
REQ-003 The status output SHALL equal flag_in when flag_we=1 in the current cycle (combinational forward), and SR otherwise.
REQ-004 An instruction SHALL be "conditional" when id_valid=1 and id_cond != 4'b1110.
REQ-005 eff_pend SHALL equal pend_cnt minus flag_we minus kill_s, computed combinationally at 3-bit width and floored at 0.
REQ-006 cond_stall SHALL be 1 exactly when the ID instruction is conditional and eff_pend > 0.
REQ-007 issue SHALL equal id_valid & ~freeze & ~cond_stall.
REQ-008 The next value of pend_cnt SHALL be pend_cnt + (issue & id_s) - flag_we - kill_s, with all three events allowed in the same cycle.
REQ-009 When issue & id_s, flag_we and kill_s are all 1 in the same cycle, the net change SHALL be -1, and SR SHALL still load flag_in.
REQ-010 pend_cnt SHALL saturate at 3: an increment at 3 SHALL hold the count at 3 and set err.
REQ-011 pend_cnt SHALL floor at 0: a net decrement below 0 SHALL hold the count at 0 and set err.
REQ-012 flag_we and kill_s both 1 while pend_cnt=1 and no increment is pending SHALL be treated as an underflow, and SHALL set err.
REQ-013 The pending-tracking states SHALL be IDLE (pend_cnt=0), WAIT1, WAIT2 and WAIT3 (pend_cnt=1, 2, 3).
- Transitions between these states follow REQ-008.
- cond_stall is possible only in the WAIT states.
REQ-014 A non-conditional (AL) instruction SHALL never stall on flags, regardless of pend_cnt.
REQ-015 freeze SHALL NOT block flag_we or kill_s from updating SR and pend_cnt.
REQ-016 err SHALL be sticky until rst.
REQ-017 The unit SHALL NOT evaluate the condition itself; status is consumed downstream by the condition checker.

Reset
REQ-018 When rst=1 at a rising edge, the module SHALL set SR=4'b0000, pend_cnt=0 and err=0, overriding flag_we, kill_s and issue in that cycle.
REQ-019 During the rst cycle, status SHALL still follow REQ-003 combinationally.
REQ-020 Reset mid-operation SHALL discard all pending counts, so a flag_we in the cycle after reset with pend_cnt=0 sets err.

Verification
REQ-021 Forwarding:
- stimulus: SR=0000; flag_we=1, flag_in=4'b1000; id_cond=0000, id_valid=1, pend_cnt=1.
- response: status=1000, cond_stall=0, issue=1; next cycle SR=1000, pend_cnt=0.
REQ-022 Stall:
- stimulus: issue an S instruction (id_s=1, AL); next cycle present id_cond=0001 with no flag_we.
- response: cond_stall=1, issue=0, pend_cnt=1; the cycle flag_we=1 arrives, cond_stall=0 and issue=1.
REQ-023 Simultaneous events:
- stimulus: pend_cnt=2; in one cycle issue&id_s=1, flag_we=1, kill_s=1.
- response: pend_cnt=1 next cycle; SR=flag_in; err=0.
REQ-024 Saturation and underflow:
- stimulus: four consecutive S issues with no flag_we.
- response: pend_cnt=3 and err=1 after the fourth issue.
- stimulus: after rst, flag_we=1.
- response: pend_cnt=0 and err=1.
REQ-025 Freeze:
- stimulus: freeze=1, id_valid=1, id_s=1, pend_cnt=1, flag_we=1.
- response: issue=0, pend_cnt=0 next cycle, SR updated.
REQ-026 Reset priority:
- stimulus: rst=1 with flag_we=1, flag_in=4'b1111, pend_cnt=2.
- response: next cycle SR=0000, pend_cnt=0, err=0.

Source files
------------

// File: rtl/status_unit.sv
// Status-flag register with in-flight flag-writer tracking.
// It stalls conditional ID instructions until every pending flag writer has committed or been squashed.
module status_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       id_valid,
    input  logic       id_s,
    input  logic [3:0] id_cond,
    input  logic       flag_we,
    input  logic [3:0] flag_in,
    input  logic       kill_s,
    output logic [3:0] status,
    output logic       cond_stall,
    output logic       issue,
    output logic [1:0] pend_cnt,
    output logic       err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] WAIT2 = 2'd2;
    localparam logic [1:0] WAIT3 = 2'd3;

    localparam logic [3:0] COND_AL = 4'b1110;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] sr;
    logic       err_nxt;
    logic       is_cond;
    logic       inc;
    logic [2:0] dec;
    logic [2:0] up;
    logic [2:0] net;
    logic [2:0] eff_pend;

    assign dec      = {2'b00, flag_we} + {2'b00, kill_s};
    assign eff_pend = ({1'b0, state} > dec) ? ({1'b0, state} - dec) : '0;

    // A conditional instruction waits only while some writer remains unresolved after this cycle.
    assign is_cond    = id_valid && (id_cond != COND_AL);
    assign cond_stall = is_cond && (state != IDLE) && (eff_pend != '0);
    assign issue      = id_valid & ~freeze & ~cond_stall;
    assign inc        = issue & id_s;

    assign up  = {1'b0, state} + {2'b00, inc};
    assign net = up - dec;

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        if (up < dec) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (net > {1'b0, WAIT3}) begin
            state_nxt = WAIT3;
            err_nxt   = 1'b1;
        end else begin
            state_nxt = net[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            if (flag_we) begin
                sr <= flag_in;
            end
            state <= state_nxt;
            err   <= err_nxt;
        end
    end

    assign status   = flag_we ? flag_in : sr;
    assign pend_cnt = state;

endmodule

// File: tb/tb_status_unit.sv
// Testbench for status_unit: directed scenarios followed by random traffic.
// Every output is checked each cycle against an arithmetic reference model.
module tb_status_unit;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic       id_valid;
    logic       id_s;
    logic [3:0] id_cond;
    logic       flag_we;
    logic [3:0] flag_in;
    logic       kill_s;
    logic [3:0] status;
    logic       cond_stall;
    logic       issue;
    logic [1:0] pend_cnt;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_pend;
    logic [3:0] m_sr;
    logic       m_err;

    status_unit dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .id_valid   (id_valid),
        .id_s       (id_s),
        .id_cond    (id_cond),
        .flag_we    (flag_we),
        .flag_in    (flag_in),
        .kill_s     (kill_s),
        .status     (status),
        .cond_stall (cond_stall),
        .issue      (issue),
        .pend_cnt   (pend_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fz, input logic v, input logic s,
                         input logic [3:0] c, input logic we, input logic [3:0] fin,
                         input logic k);
        @(negedge clk);
        rst      = r;
        freeze   = fz;
        id_valid = v;
        id_s     = s;
        id_cond  = c;
        flag_we  = we;
        flag_in  = fin;
        kill_s   = k;
        #1;
    endtask

    // Check the current cycle against the model, then clock and advance the model.
    task automatic commit();
        int  eff;
        int  nxt;
        bit  cnd;
        bit  stl;
        bit  iss;
        cnd = id_valid && (id_cond != 4'd14);
        eff = m_pend - int'(flag_we) - int'(kill_s);
        if (eff < 0) eff = 0;
        stl = cnd && (eff > 0);
        iss = id_valid && !freeze && !stl;
        check("status", status, flag_we ? flag_in : m_sr);
        check("cond_stall", {3'b0, cond_stall}, {3'b0, stl});
        check("issue", {3'b0, issue}, {3'b0, iss});
        check("pend_cnt", {2'b0, pend_cnt}, 4'(m_pend));
        check("err", {3'b0, err}, {3'b0, m_err});
        @(posedge clk);
        if (rst) begin
            m_sr   = 4'b0000;
            m_pend = 0;
            m_err  = 1'b0;
        end else begin
            if (flag_we) m_sr = flag_in;
            nxt = m_pend + int'(iss && id_s) - int'(flag_we) - int'(kill_s);
            if (nxt > 3) begin
                nxt   = 3;
                m_err = 1'b1;
            end
            if (nxt < 0) begin
                nxt   = 0;
                m_err = 1'b1;
            end
            m_pend = nxt;
        end
        #1;
    endtask

    task automatic step(input logic r, input logic fz, input logic v, input logic s,
                        input logic [3:0] c, input logic we, input logic [3:0] fin,
                        input logic k);
        drive(r, fz, v, s, c, we, fin, k);
        commit();
    endtask

    initial begin
        m_pend = 0;
        m_sr   = '0;
        m_err  = 1'b0;

        // Reset: the model starts from the reset state, so this cycle is not compared.
        drive(1, 0, 0, 0, 4'he, 0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("rst_pend", {2'b0, pend_cnt}, 4'd0);
        check("rst_err", {3'b0, err}, 4'd0);
        check("rst_status", status, 4'b0000);

        // Forwarding with one pending writer.
        step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        drive(0, 0, 1, 0, 4'h0, 1, 4'b1000, 0);
        check("fwd_status", status, 4'b1000);
        check("fwd_stall", {3'b0, cond_stall}, 4'd0);
        check("fwd_issue", {3'b0, issue}, 4'd1);
        commit();
        check("fwd_pend_next", {2'b0, pend_cnt}, 4'd0);
        drive(0, 0, 0, 0, 4'he, 0, 4'h0, 0);
        check("fwd_sr", status, 4'b1000);
        commit();

        // Conditional stall until the flags commit.
        step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        drive(0, 0, 1, 0, 4'h1, 0, 4'h0, 0);
        check("stall_on", {3'b0, cond_stall}, 4'd1);
        check("stall_issue", {3'b0, issue}, 4'd0);
        check("stall_pend", {2'b0, pend_cnt}, 4'd1);
        commit();
        drive(0, 0, 1, 0, 4'h1, 1, 4'b0100, 0);
        check("stall_release", {3'b0, cond_stall}, 4'd0);
        check("stall_release_issue", {3'b0, issue}, 4'd1);
        commit();

        // Increment, commit and squash together.
        step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        step(0, 0, 1, 1, 4'he, 1, 4'b0011, 1);
        check("simul_pend", {2'b0, pend_cnt}, 4'd1);
        check("simul_err", {3'b0, err}, 4'd0);
        drive(0, 0, 0, 0, 4'he, 0, 4'h0, 0);
        check("simul_sr", status, 4'b0011);
        commit();
        step(0, 0, 0, 0, 4'he, 1, 4'h0, 0);

        // Freeze does not block commits.
        step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        drive(0, 1, 1, 1, 4'he, 1, 4'b0110, 0);
        check("frz_issue", {3'b0, issue}, 4'd0);
        commit();
        check("frz_pend", {2'b0, pend_cnt}, 4'd0);
        step(0, 0, 0, 0, 4'he, 0, 4'h0, 0);

        // Saturation after four issues.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'he, 0, 4'h0, 0);
        check("sat_pend", {2'b0, pend_cnt}, 4'd3);
        check("sat_err", {3'b0, err}, 4'd1);

        // Reset priority over a commit, then underflow right after reset.
        step(0, 0, 0, 0, 4'he, 1, 4'h0, 0);
        drive(1, 0, 0, 0, 4'he, 1, 4'b1111, 0);
        check("rstcyc_status", status, 4'b1111);
        commit();
        check("rstpri_pend", {2'b0, pend_cnt}, 4'd0);
        check("rstpri_err", {3'b0, err}, 4'd0);
        drive(0, 0, 0, 0, 4'he, 0, 4'h0, 0);
        check("rstpri_sr", status, 4'b0000);
        commit();
        step(0, 0, 0, 0, 4'he, 1, 4'b0101, 0);
        check("undf_pend", {2'b0, pend_cnt}, 4'd0);
        check("undf_err", {3'b0, err}, 4'd1);
        step(1, 0, 0, 0, 4'he, 0, 4'h0, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 75),
                 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom),
                 ($urandom_range(0, 99) < 30),
                 4'($urandom),
                 ($urandom_range(0, 99) < 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
